sysid_checker: RTL and testbench
================================

// Module: sysid_checker
// PURPOSE
//  Avalon-MM read master that sits upstream of the system-ID slave and consumes its readdata.
//  After reset, or on a start pulse, it reads the ID word (offset 0) and the timestamp word (offset 1).
//  It compares both against the expected values, latches them, and raises pass/fail flags.
//  Flags are visible to the LED/hex status logic and to a CPU-readable status register.
// PARAMETERS
//  ADDR_W         16          byte-address width of avm_address
//  BASE_ADDR      16'h0000    byte base address of the sysid slave
//  EXP_ID         32'd0       expected value at offset 0
//  EXP_TIMESTAMP  1524785788  expected value at offset 1 (byte offset +4)
//  TIMEOUT_CYC    255         max cycles per read transaction before abort (1..65535)
//  AUTO_START     1           1: begin a check automatically after reset release
// PORTS
//  clock              in   1       system clock
//  reset_n            in   1       asynchronous active-low reset
//  start              in   1       1-cycle pulse; starts a check when not busy
//  avm_address        out  ADDR_W  byte address: BASE_ADDR or BASE_ADDR+4
//  avm_read           out  1       read request
//  avm_waitrequest    in   1       slave stall; request held while high
//  avm_readdata       in   32      read data
//  avm_readdatavalid  in   1       read data valid
//  busy               out  1       check in progress
//  done               out  1       sticky; set when a check finishes, cleared by the next start
//  pass               out  1       sticky; ID and timestamp both matched
//  fail               out  1       sticky; mismatch or timeout
//  timeout            out  1       sticky; fail was caused by the timeout
//  id_q               out  32      captured ID word
//  ts_q               out  32      captured timestamp word
// BEHAVIOUR
//  Reset: all outputs are 0; FSM is in IDLE; timer is 0. Reset mid-operation aborts at once.
//   No partial flags survive the reset.
//  FSM states: IDLE -> ID_REQ -> ID_WAIT -> TS_REQ -> TS_WAIT -> CHECK -> FIN.
//  IDLE: go to ID_REQ on start, or on the first cycle after reset release when AUTO_START=1.
//   Entering ID_REQ clears done/pass/fail/timeout.
//  *_REQ: assert avm_read with the matching address and hold both stable while avm_waitrequest=1.
//   The request is accepted in the cycle where avm_waitrequest=0; then go to *_WAIT.
//   If avm_readdatavalid=1 in the acceptance cycle (zero-latency slave), capture the data now.
//   In that case skip *_WAIT and go straight to the next REQ, or to CHECK.
//  *_WAIT: avm_read=0. On avm_readdatavalid, capture avm_readdata into id_q/ts_q and advance.
//  CHECK (1 cycle): pass = (id_q==EXP_ID)&&(ts_q==EXP_TIMESTAMP); fail = !pass; go to FIN.
//  FIN: done=1, busy=0. A start pulse re-runs the check: go to ID_REQ.
//  busy = 1 in every state except IDLE and FIN.
//  Timer: reloads to 0 on entry to each REQ state and increments every cycle in REQ/WAIT.
//   When it reaches TIMEOUT_CYC before that read completes: drop avm_read at once.
//   Then set fail=1, timeout=1, pass=0, done=1, and go to FIN. id_q/ts_q keep their last values.
//  start while busy is ignored. avm_readdatavalid outside *_WAIT/acceptance cycles is ignored.
//  Latency with a zero-wait, zero-latency slave: start at cycle 0 -> done=1 at cycle 4.
//   (ID_REQ c1, TS_REQ c2, CHECK c3, FIN c4.)
//  The comparison is full 32-bit equality; no masking.
// STRUCTURE
//  Package sysid_chk_pkg: state enum (IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, CHECK, FIN);
//   constants OFS_ID=0 and OFS_TS=4.
//  Sub-module sysid_chk_timer: loadable up-counter with a terminal-count output.
//   Its width is $clog2(TIMEOUT_CYC+1).
//  Top level: FSM, address mux, capture registers, flag registers.
// TESTING
//  1 Zero-latency slave returning 0 / 1524785788, AUTO_START=1 -> reads at BASE, BASE+4;
//    pass=1 and fail=0 at cycle 4 after reset release.
//  2 Timestamp returned as 1524785789 -> id_q=0, ts_q=1524785789, fail=1, pass=0, timeout=0.
//  3 waitrequest high for 5 cycles on each read, then readdatavalid 2 cycles after acceptance
//    -> address/read stay stable while stalled; pass=1.
//  4 readdatavalid never asserted, TIMEOUT_CYC=8 -> avm_read drops;
//    fail=1 and timeout=1 in cycle 9 after ID_REQ entry.
//  5 reset_n pulsed low during TS_WAIT -> all outputs 0 immediately;
//    with AUTO_START=1 the check restarts and passes.
//  6 start pulsed while busy -> ignored.
//    start pulsed in FIN -> flags clear and a second check completes with pass=1.

Source files
------------

// File: rtl/sysid_chk_pkg.sv
// sysid_chk_pkg
//   Shared types and constants for the system-ID checker.
//   state_t : checker FSM states
//   OFS_ID  : byte offset of the ID word inside the sysid slave
//   OFS_TS  : byte offset of the timestamp word inside the sysid slave
package sysid_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        CHECK,
        FIN
    } state_t;

    localparam int unsigned OFS_ID = 0;
    localparam int unsigned OFS_TS = 4;

endpackage

// File: rtl/sysid_chk_timer.sv
// sysid_chk_timer
//   Loadable up-counter that bounds the duration of one read transaction.
//   Ports:
//     clock    in  system clock
//     reset_n  in  asynchronous active-low reset
//     i_load   in  reload the count to 0 (wins over i_en)
//     i_en     in  count one cycle
//     o_tc     out count has reached TIMEOUT_CYC
module sysid_chk_timer #(
    parameter int unsigned TIMEOUT_CYC = 255,
    localparam int unsigned W          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [W-1:0] TC = W'(TIMEOUT_CYC);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == TC);

    // Holds at the terminal count so it can never wrap back to 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en && !o_tc) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker
//   Avalon-MM read master that reads the sysid slave ID word (offset 0) and
//   timestamp word (offset 4), compares them against the expected values and
//   reports sticky pass/fail/timeout flags.
//   Ports:
//     clock, reset_n          clock / asynchronous active-low reset
//     start                   1-cycle pulse, starts a check when not busy
//     avm_address, avm_read   read request (address is BASE or BASE+4)
//     avm_waitrequest         slave stall; request held while high
//     avm_readdata/valid      read response
//     busy                    check in progress
//     done, pass, fail        sticky result flags, cleared by the next start
//     timeout                 fail was caused by a transaction timeout
//     id_q, ts_q              captured ID / timestamp words
module sysid_checker
    import sysid_chk_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter logic [31:0]       EXP_ID        = 32'd0,
    parameter logic [31:0]       EXP_TIMESTAMP = 32'd1524785788,
    parameter int unsigned       TIMEOUT_CYC   = 255,
    parameter bit                AUTO_START    = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [31:0]       id_q,
    output logic [31:0]       ts_q
);

    state_t      r_state;
    state_t      w_next;
    logic        r_arm;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic        r_timeout;
    logic [31:0] r_id;
    logic [31:0] r_ts;

    logic w_tc;
    logic w_in_req;
    logic w_in_wait;
    logic w_active;
    logic w_rd_req;
    logic w_accept;
    logic w_rd_done;
    logic w_id_cap;
    logic w_ts_cap;
    logic w_timeout;
    logic w_start_chk;
    logic w_load;
    logic w_match;

    assign w_in_req  = (r_state == ID_REQ) || (r_state == TS_REQ);
    assign w_in_wait = (r_state == ID_WAIT) || (r_state == TS_WAIT);
    assign w_active  = w_in_req || w_in_wait;

    // The request is withdrawn in the very cycle the timer expires.
    assign w_rd_req  = w_in_req && !w_tc;
    assign w_accept  = w_rd_req && !avm_waitrequest;

    // Data counts either in the acceptance cycle (zero-latency slave) or
    // while waiting; a response landing on the timeout cycle loses.
    assign w_rd_done = (w_accept && avm_readdatavalid) ||
                       (w_in_wait && avm_readdatavalid && !w_tc);
    assign w_id_cap  = w_rd_done && ((r_state == ID_REQ) || (r_state == ID_WAIT));
    assign w_ts_cap  = w_rd_done && ((r_state == TS_REQ) || (r_state == TS_WAIT));
    assign w_timeout = w_active && w_tc;
    assign w_match   = (r_id == EXP_ID) && (r_ts == EXP_TIMESTAMP);

    assign w_start_chk = (w_next == ID_REQ) && (r_state != ID_REQ);
    assign w_load      = w_start_chk || ((w_next == TS_REQ) && (r_state != TS_REQ));

    sysid_chk_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clock  (clock),
        .reset_n(reset_n),
        .i_load (w_load),
        .i_en   (w_active),
        .o_tc   (w_tc)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start || r_arm) w_next = ID_REQ;
            end
            ID_REQ: begin
                if (w_tc)          w_next = FIN;
                else if (w_accept) w_next = avm_readdatavalid ? TS_REQ : ID_WAIT;
            end
            ID_WAIT: begin
                if (w_tc)                   w_next = FIN;
                else if (avm_readdatavalid) w_next = TS_REQ;
            end
            TS_REQ: begin
                if (w_tc)          w_next = FIN;
                else if (w_accept) w_next = avm_readdatavalid ? CHECK : TS_WAIT;
            end
            TS_WAIT: begin
                if (w_tc)                   w_next = FIN;
                else if (avm_readdatavalid) w_next = CHECK;
            end
            CHECK:   w_next = FIN;
            FIN: begin
                if (start) w_next = ID_REQ;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_arm   <= AUTO_START;
        end else begin
            r_state <= w_next;
            // Auto-start only applies to the first cycle after reset release.
            r_arm   <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_start_chk) begin
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (r_state == CHECK) begin
            r_done    <= 1'b1;
            r_pass    <= w_match;
            r_fail    <= !w_match;
        end else if (w_timeout) begin
            r_done    <= 1'b1;
            r_pass    <= 1'b0;
            r_fail    <= 1'b1;
            r_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_id <= '0;
            r_ts <= '0;
        end else begin
            if (w_id_cap) r_id <= avm_readdata;
            if (w_ts_cap) r_ts <= avm_readdata;
        end
    end

    // Address is a pure function of state so it stays put during stalls.
    always_comb begin
        avm_address = '0;
        if (r_state == ID_REQ)      avm_address = BASE_ADDR + ADDR_W'(OFS_ID);
        else if (r_state == TS_REQ) avm_address = BASE_ADDR + ADDR_W'(OFS_TS);
    end

    assign avm_read = w_rd_req;
    assign busy     = (r_state != IDLE) && (r_state != FIN);
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign timeout  = r_timeout;
    assign id_q     = r_id;
    assign ts_q     = r_ts;

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker
//   Drives sysid_checker against a configurable behavioural sysid slave
//   (stall cycles, response latency, never-respond) and checks results
//   through a scoreboard queue plus a few hand-written corner sequences.
module tb_sysid_checker;

    localparam logic [15:0] BASE   = 16'h0040;
    localparam logic [31:0] EXP_TS = 32'd1524785788;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [15:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy, done, pass, fail, timeout;
    logic [31:0] id_q, ts_q;

    sysid_checker #(
        .ADDR_W       (16),
        .BASE_ADDR    (BASE),
        .EXP_ID       (32'd0),
        .EXP_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYC  (8),
        .AUTO_START   (1'b1)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail             (fail),
        .timeout          (timeout),
        .id_q             (id_q),
        .ts_q             (ts_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural slave ----------------
    logic [31:0] cfg_id, cfg_ts;
    int          cfg_wait;   // stall cycles per request
    int          cfg_lat;    // 0: same cycle, N: N cycles after accept, <0: never
    int          stall_cnt;
    int          dly;
    logic        pend;
    logic [31:0] pend_data;
    logic        s_accept;

    assign avm_waitrequest   = avm_read && (stall_cnt < cfg_wait);
    assign s_accept          = avm_read && !avm_waitrequest;
    assign avm_readdatavalid = (cfg_lat == 0 && s_accept) || (pend && dly == 0);
    assign avm_readdata      = (cfg_lat == 0 && s_accept) ?
                               ((avm_address == BASE) ? cfg_id : cfg_ts) :
                               (pend && dly == 0) ? pend_data : 32'h0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 0;
            pend      <= 1'b0;
            dly       <= 0;
            pend_data <= 32'h0;
        end else begin
            if (pend && dly == 0) pend <= 1'b0;
            else if (pend)        dly  <= dly - 1;
            if (avm_read && avm_waitrequest) begin
                stall_cnt <= stall_cnt + 1;
            end else if (s_accept) begin
                stall_cnt <= 0;
                if (cfg_lat > 0) begin
                    pend      <= 1'b1;
                    dly       <= cfg_lat - 1;
                    pend_data <= (avm_address == BASE) ? cfg_id : cfg_ts;
                end
            end else begin
                stall_cnt <= 0;
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [15:0] acc_q[$];
    logic        r_pw;
    logic [15:0] r_pa;
    int          stab_err;

    initial begin
        r_pw     = 1'b0;
        r_pa     = 16'h0;
        stab_err = 0;
    end

    always @(posedge clock) begin
        if (avm_read && !avm_waitrequest) acc_q.push_back(avm_address);
        if (r_pw && avm_read && avm_address != r_pa) stab_err <= stab_err + 1;
        r_pw <= avm_read && avm_waitrequest;
        r_pa <= avm_address;
    end

    // ---------------- checking ----------------
    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        int          wt;
        int          lat;
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [31:0] eid;
        logic [31:0] ets;
        int          lat_exp;   // cycles from start to done; 0 = not checked
        int          nacc;      // accepted reads expected
    } vec_t;

    vec_t tbl[8];
    vec_t sb_q[$];
    int   n_tests;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input bit auto_go, input string nm);
        vec_t e;
        int   k;
        bit   got;
        cfg_id   = v.id;
        cfg_ts   = v.ts;
        cfg_wait = v.wt;
        cfg_lat  = v.lat;
        acc_q.delete();
        sb_q.push_back(v);
        if (auto_go) reset_n = 1'b1;
        else         start   = 1'b1;
        got = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (k == 1) begin
                start = 1'b0;
                chk({nm, ".clr"}, {28'h0, done, pass, fail, timeout}, 32'h0);
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        e = sb_q.pop_front();
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.done: done not seen within 200 cycles, expected within %0d", nm, e.lat_exp);
        end else begin
            if (e.lat_exp > 0) chk({nm, ".lat"}, 32'(k), 32'(e.lat_exp));
            chk({nm, ".pass"}, {31'h0, pass}, {31'h0, e.pass});
            chk({nm, ".fail"}, {31'h0, fail}, {31'h0, e.fail});
            chk({nm, ".tmo"},  {31'h0, timeout}, {31'h0, e.tmo});
            chk({nm, ".id"},   id_q, e.eid);
            chk({nm, ".ts"},   ts_q, e.ets);
            chk({nm, ".busy"}, {31'h0, busy}, 32'h0);
            chk({nm, ".nacc"}, 32'(acc_q.size()), 32'(e.nacc));
            if (acc_q.size() >= 1) chk({nm, ".a0"}, {16'h0, acc_q[0]}, {16'h0, BASE});
            if (acc_q.size() >= 2) chk({nm, ".a1"}, {16'h0, acc_q[1]}, {16'h0, BASE + 16'd4});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        cfg_id  = 32'h0;
        cfg_ts  = EXP_TS;
        cfg_wait = 0;
        cfg_lat  = 0;

        //             id            ts          wt lat  pass fail tmo  eid           ets         lat nacc
        tbl[0] = '{32'h0,        EXP_TS,       0,  0, 1'b1, 1'b0, 1'b0, 32'h0,        EXP_TS,       4, 2};
        tbl[1] = '{32'h0,        EXP_TS + 1,   0,  0, 1'b0, 1'b1, 1'b0, 32'h0,        EXP_TS + 1,   4, 2};
        tbl[2] = '{32'h0,        EXP_TS,       5,  2, 1'b1, 1'b0, 1'b0, 32'h0,        EXP_TS,      18, 2};
        tbl[3] = '{32'h1,        EXP_TS,       0,  0, 1'b0, 1'b1, 1'b0, 32'h1,        EXP_TS,       4, 2};
        tbl[4] = '{32'h8000_0000, EXP_TS,      0,  1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, EXP_TS,      6, 2};
        tbl[5] = '{32'h0,        EXP_TS,       0, -1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, EXP_TS,     10, 1};
        tbl[6] = '{32'h0,        EXP_TS,       2,  1, 1'b1, 1'b0, 1'b0, 32'h0,        EXP_TS,      10, 2};
        tbl[7] = '{EXP_TS,       EXP_TS,       0,  0, 1'b0, 1'b1, 1'b0, EXP_TS,       EXP_TS,       4, 2};

        // reset state
        repeat (2) @(negedge clock);
        chk("rst.flags", {26'h0, busy, done, pass, fail, timeout, avm_read}, 32'h0);
        chk("rst.addr",  {16'h0, avm_address}, 32'h0);
        chk("rst.id",    id_q, 32'h0);
        chk("rst.ts",    ts_q, 32'h0);

        // auto-start after reset release, zero-latency slave
        run(tbl[0], 1'b1, "auto");

        for (int i = 0; i < 8; i++) run(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // timeout with waitrequest stuck high: read drops 8 cycles into ID_REQ
        begin
            bit ok_wait;
            cfg_wait = 1000;
            cfg_lat  = 0;
            start    = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clock);
                if (k == 1) start = 1'b0;
                if (k == 8) chk("tmo.read_c7", {15'h0, avm_read, avm_address}, {15'h0, 1'b1, BASE});
                if (k == 9) chk("tmo.read_c8", {30'h0, avm_read, fail}, 32'h0);
                if (k == 10) begin
                    chk("tmo.flags", {27'h0, done, pass, fail, timeout, busy}, {27'h0, 5'b10110});
                    chk("tmo.keep_id", id_q, EXP_TS);
                    chk("tmo.keep_ts", ts_q, EXP_TS);
                end
            end
            cfg_wait = 0;
            ok_wait  = 1'b0;

            // reset during TS_WAIT aborts at once, then auto-start re-runs
            cfg_id  = 32'h0;
            cfg_ts  = EXP_TS;
            cfg_lat = 3;
            start   = 1'b1;
            for (int k = 1; k <= 50; k++) begin
                @(negedge clock);
                start = 1'b0;
                if (avm_read && avm_address == BASE + 16'd4) begin
                    ok_wait = 1'b1;
                    break;
                end
            end
            if (!ok_wait) begin
                n_tests++;
                n_fail++;
                $display("FAIL rst_mid.wait: TS request not seen within 50 cycles");
            end
            @(negedge clock);
            chk("rst_mid.busy", {31'h0, busy}, 32'h1);
            #1 reset_n = 1'b0;
            #1;
            chk("rst_mid.flags", {26'h0, busy, done, pass, fail, timeout, avm_read}, 32'h0);
            chk("rst_mid.id", id_q, 32'h0);
            chk("rst_mid.ts", ts_q, 32'h0);
            repeat (2) @(negedge clock);
            run(tbl[0], 1'b1, "rst_mid.rerun");
        end

        // start while busy is ignored
        cfg_id   = 32'h0;
        cfg_ts   = EXP_TS;
        cfg_wait = 0;
        cfg_lat  = 0;
        acc_q.delete();
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        chk("busy_start.c4", {30'h0, done, pass}, 32'h3);
        repeat (2) @(negedge clock);
        chk("busy_start.c6", {30'h0, done, busy}, 32'h2);
        chk("busy_start.nacc", 32'(acc_q.size()), 32'd2);

        // start in FIN re-runs the check
        run(tbl[1], 1'b0, "fin_restart.fail");
        run(tbl[0], 1'b0, "fin_restart.pass");

        chk("stall.stable", 32'(stab_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
